// File: rtl/shf_arb.sv
// Round-robin two-port arbiter that issues ops to the shared shifter and returns
// registered responses after a fixed three-cycle latency.
module shf_arb #(
    parameter int unsigned DATASIZE = 16,
    parameter int unsigned TAGW     = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,

    input  logic                i_rq0_vld,
    output logic                o_rq0_rdy,
    input  logic [1:0]          i_rq0_cls,
    input  logic [DATASIZE-1:0] i_rq0_dtx,
    input  logic [DATASIZE-1:0] i_rq0_dty,
    input  logic [TAGW-1:0]     i_rq0_tag,

    input  logic                i_rq1_vld,
    output logic                o_rq1_rdy,
    input  logic [1:0]          i_rq1_cls,
    input  logic [DATASIZE-1:0] i_rq1_dtx,
    input  logic [DATASIZE-1:0] i_rq1_dty,
    input  logic [TAGW-1:0]     i_rq1_tag,

    input  logic                i_cu_hold,

    output logic                o_ps_shf_en,
    output logic [1:0]          o_ps_shf_cls,
    output logic [DATASIZE-1:0] o_xb_dtx,
    output logic [DATASIZE-1:0] o_xb_dty,

    input  logic [DATASIZE-1:0] i_shf_xb_dt,
    input  logic                i_shf_ps_sv,
    input  logic                i_shf_ps_sz,

    output logic                o_rsp_vld,
    output logic                o_rsp_id,
    output logic [TAGW-1:0]     o_rsp_tag,
    output logic [DATASIZE-1:0] o_rsp_dt,
    output logic                o_rsp_sv,
    output logic                o_rsp_sz,

    output logic [1:0]          o_sv_sticky,
    input  logic [1:0]          i_clr_sticky,
    output logic                o_busy
);

    logic                r_ptr;
    logic                r_a_vld;
    logic [1:0]          r_a_cls;
    logic [DATASIZE-1:0] r_a_dtx;
    logic [DATASIZE-1:0] r_a_dty;
    logic                r_a_id;
    logic [TAGW-1:0]     r_a_tag;
    logic                r_b_vld;
    logic                r_b_id;
    logic [TAGW-1:0]     r_b_tag;
    logic                r_rsp_vld;
    logic                r_rsp_id;
    logic [TAGW-1:0]     r_rsp_tag;
    logic [DATASIZE-1:0] r_rsp_dt;
    logic                r_rsp_sv;
    logic                r_rsp_sz;
    logic [1:0]          r_sticky;

    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_acc;
    logic                w_acc_id;
    logic [1:0]          w_cls;
    logic [DATASIZE-1:0] w_dtx;
    logic [DATASIZE-1:0] w_dty;
    logic [TAGW-1:0]     w_tag;
    logic [1:0]          w_sv_set;

    // The pointer only breaks ties; a lone requester always wins.
    assign w_gnt0 = i_rq0_vld & (~i_rq1_vld | ~r_ptr);
    assign w_gnt1 = i_rq1_vld & (~i_rq0_vld | r_ptr);

    assign o_rq0_rdy = w_gnt0 & ~i_cu_hold & ~i_reset;
    assign o_rq1_rdy = w_gnt1 & ~i_cu_hold & ~i_reset;
    assign w_acc     = o_rq0_rdy | o_rq1_rdy;
    assign w_acc_id  = o_rq1_rdy;

    always_comb begin
        w_cls = i_rq0_cls;
        w_dtx = i_rq0_dtx;
        w_dty = i_rq0_dty;
        w_tag = i_rq0_tag;
        if (w_acc_id) begin
            w_cls = i_rq1_cls;
            w_dtx = i_rq1_dtx;
            w_dty = i_rq1_dty;
            w_tag = i_rq1_tag;
        end
    end

    // Overflow is attributed at the edge that loads the response register.
    assign w_sv_set = (r_b_vld & i_shf_ps_sv) ? (r_b_id ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr     <= 1'b0;
            r_a_vld   <= 1'b0;
            r_a_cls   <= '0;
            r_a_dtx   <= '0;
            r_a_dty   <= '0;
            r_a_id    <= 1'b0;
            r_a_tag   <= '0;
            r_b_vld   <= 1'b0;
            r_b_id    <= 1'b0;
            r_b_tag   <= '0;
            r_rsp_vld <= 1'b0;
            r_rsp_id  <= 1'b0;
            r_rsp_tag <= '0;
            r_rsp_dt  <= '0;
            r_rsp_sv  <= 1'b0;
            r_rsp_sz  <= 1'b0;
            r_sticky  <= '0;
        end else begin
            r_a_vld <= w_acc;
            if (w_acc) begin
                r_ptr   <= ~w_acc_id;
                r_a_cls <= w_cls;
                r_a_dtx <= w_dtx;
                r_a_dty <= w_dty;
                r_a_id  <= w_acc_id;
                r_a_tag <= w_tag;
            end

            r_b_vld <= r_a_vld;
            r_b_id  <= r_a_id;
            r_b_tag <= r_a_tag;

            r_rsp_vld <= r_b_vld;
            if (r_b_vld) begin
                r_rsp_id  <= r_b_id;
                r_rsp_tag <= r_b_tag;
                r_rsp_dt  <= i_shf_xb_dt;
                r_rsp_sv  <= i_shf_ps_sv;
                r_rsp_sz  <= i_shf_ps_sz;
            end

            r_sticky <= (r_sticky & ~i_clr_sticky) | w_sv_set;
        end
    end

    assign o_ps_shf_en  = r_a_vld;
    assign o_ps_shf_cls = r_a_cls;
    assign o_xb_dtx     = r_a_dtx;
    assign o_xb_dty     = r_a_dty;
    assign o_rsp_vld    = r_rsp_vld;
    assign o_rsp_id     = r_rsp_id;
    assign o_rsp_tag    = r_rsp_tag;
    assign o_rsp_dt     = r_rsp_dt;
    assign o_rsp_sv     = r_rsp_sv;
    assign o_rsp_sz     = r_rsp_sz;
    assign o_sv_sticky  = r_sticky;
    assign o_busy       = r_a_vld | r_b_vld | r_rsp_vld;

endmodule

// File: tb/tb_shf_arb.sv
// Directed bench for shf_arb: a behavioural shifter, a cycle model of the arbiter
// and a response scoreboard keyed by expected arrival cycle.
module tb_shf_arb;

    localparam int unsigned DW = 16;
    localparam int unsigned TW = 4;

    logic          clk;
    logic          i_reset;
    logic          i_rq0_vld, i_rq1_vld;
    logic          o_rq0_rdy, o_rq1_rdy;
    logic [1:0]    i_rq0_cls, i_rq1_cls;
    logic [DW-1:0] i_rq0_dtx, i_rq0_dty, i_rq1_dtx, i_rq1_dty;
    logic [TW-1:0] i_rq0_tag, i_rq1_tag;
    logic          i_cu_hold;
    logic          o_ps_shf_en;
    logic [1:0]    o_ps_shf_cls;
    logic [DW-1:0] o_xb_dtx, o_xb_dty;
    logic [DW-1:0] i_shf_xb_dt;
    logic          i_shf_ps_sv, i_shf_ps_sz;
    logic          o_rsp_vld, o_rsp_id;
    logic [TW-1:0] o_rsp_tag;
    logic [DW-1:0] o_rsp_dt;
    logic          o_rsp_sv, o_rsp_sz;
    logic [1:0]    o_sv_sticky;
    logic [1:0]    i_clr_sticky;
    logic          o_busy;

    shf_arb #(.DATASIZE(DW), .TAGW(TW)) u_dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_rq0_vld(i_rq0_vld), .o_rq0_rdy(o_rq0_rdy), .i_rq0_cls(i_rq0_cls),
        .i_rq0_dtx(i_rq0_dtx), .i_rq0_dty(i_rq0_dty), .i_rq0_tag(i_rq0_tag),
        .i_rq1_vld(i_rq1_vld), .o_rq1_rdy(o_rq1_rdy), .i_rq1_cls(i_rq1_cls),
        .i_rq1_dtx(i_rq1_dtx), .i_rq1_dty(i_rq1_dty), .i_rq1_tag(i_rq1_tag),
        .i_cu_hold(i_cu_hold),
        .o_ps_shf_en(o_ps_shf_en), .o_ps_shf_cls(o_ps_shf_cls),
        .o_xb_dtx(o_xb_dtx), .o_xb_dty(o_xb_dty),
        .i_shf_xb_dt(i_shf_xb_dt), .i_shf_ps_sv(i_shf_ps_sv), .i_shf_ps_sz(i_shf_ps_sz),
        .o_rsp_vld(o_rsp_vld), .o_rsp_id(o_rsp_id), .o_rsp_tag(o_rsp_tag),
        .o_rsp_dt(o_rsp_dt), .o_rsp_sv(o_rsp_sv), .o_rsp_sz(o_rsp_sz),
        .o_sv_sticky(o_sv_sticky), .i_clr_sticky(i_clr_sticky), .o_busy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shifter result packed as {dt, sv, sz}.
    function automatic logic [DW+1:0] shf_model(input logic [1:0] cls,
                                                input logic [DW-1:0] x,
                                                input logic [DW-1:0] y);
        int                   n;
        int                   cnt;
        logic                 done;
        logic [DW-1:0]        r;
        logic signed [DW-1:0] rs;
        logic                 sv;
        n    = int'(y[3:0]);
        cnt  = 0;
        done = 1'b0;
        sv   = 1'b0;
        r    = '0;
        case (cls)
            2'b00: begin
                r  = x << n;
                rs = r;
                sv = ((rs >>> n) != $signed(x));
            end
            2'b01: r = (x << n) | (x >> (DW - n));
            default: begin
                for (int i = DW - 1; i >= 0; i--) begin
                    if (!done && (x[i] == cls[0])) cnt++;
                    else done = 1'b1;
                end
                r  = DW'(cnt);
                sv = (cnt == DW);
            end
        endcase
        return {r, sv, (r == '0)};
    endfunction

    logic [DW+1:0] r_shf;
    initial r_shf = '0;
    always_ff @(posedge clk) begin
        if (o_ps_shf_en) r_shf <= shf_model(o_ps_shf_cls, o_xb_dtx, o_xb_dty);
    end
    assign {i_shf_xb_dt, i_shf_ps_sv, i_shf_ps_sz} = r_shf;

    typedef struct {
        int            cyc;
        logic          id;
        logic [TW-1:0] tag;
        logic [DW-1:0] dt;
        logic          sv;
        logic          sz;
    } rsp_t;

    rsp_t          sb[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    logic          m_ptr, h1, h2, h3;
    logic [1:0]    m_sticky, m_clr_q, m_cls;
    logic [DW-1:0] m_x, m_y;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_ptr = 1'b0; h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        m_sticky = '0; m_clr_q = '0; m_cls = '0; m_x = '0; m_y = '0;
        sb.delete();
    endtask

    // Check one cycle against the model, then advance to the next negedge.
    task automatic tick();
        rsp_t          e;
        logic          ev, r0, r1, acc;
        logic [1:0]    set;
        logic [DW+1:0] res;
        #1;
        ev = 1'b0;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            ev = 1'b1;
            e  = sb.pop_front();
        end
        chk("rsp_vld", 32'(o_rsp_vld), 32'(ev));
        set = 2'b00;
        if (ev) begin
            chk("rsp_id", 32'(o_rsp_id), 32'(e.id));
            chk("rsp_tag", 32'(o_rsp_tag), 32'(e.tag));
            chk("rsp_dt", 32'(o_rsp_dt), 32'(e.dt));
            chk("rsp_sv", 32'(o_rsp_sv), 32'(e.sv));
            chk("rsp_sz", 32'(o_rsp_sz), 32'(e.sz));
            if (e.sv) set = e.id ? 2'b10 : 2'b01;
        end
        m_sticky = (m_sticky & ~m_clr_q) | set;
        chk("sv_sticky", 32'(o_sv_sticky), 32'(m_sticky));
        m_clr_q = i_clr_sticky;

        r0 = i_rq0_vld & (!i_rq1_vld | !m_ptr) & !i_cu_hold & !i_reset;
        r1 = i_rq1_vld & (!i_rq0_vld | m_ptr) & !i_cu_hold & !i_reset;
        chk("rq0_rdy", 32'(o_rq0_rdy), 32'(r0));
        chk("rq1_rdy", 32'(o_rq1_rdy), 32'(r1));
        chk("shf_en", 32'(o_ps_shf_en), 32'(h1));
        chk("busy", 32'(o_busy), 32'(h1 | h2 | h3));
        chk("shf_cls", 32'(o_ps_shf_cls), 32'(m_cls));
        chk("xb_dtx", 32'(o_xb_dtx), 32'(m_x));
        chk("xb_dty", 32'(o_xb_dty), 32'(m_y));

        acc = r0 | r1;
        h3 = h2; h2 = h1; h1 = acc;
        if (acc) begin
            m_ptr = r0;
            m_cls = r1 ? i_rq1_cls : i_rq0_cls;
            m_x   = r1 ? i_rq1_dtx : i_rq0_dtx;
            m_y   = r1 ? i_rq1_dty : i_rq0_dty;
            res   = shf_model(m_cls, m_x, m_y);
            e.cyc = cyc + 3;
            e.id  = r1;
            e.tag = r1 ? i_rq1_tag : i_rq0_tag;
            {e.dt, e.sv, e.sz} = res;
            sb.push_back(e);
        end
        if (i_reset) model_clear();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle();
        i_rq0_vld = 1'b0;
        i_rq1_vld = 1'b0;
    endtask

    task automatic req(input int n, input logic [1:0] cls, input logic [DW-1:0] x,
                       input logic [DW-1:0] y, input logic [TW-1:0] tag);
        if (n == 0) begin
            i_rq0_vld = 1'b1; i_rq0_cls = cls; i_rq0_dtx = x; i_rq0_dty = y; i_rq0_tag = tag;
        end else begin
            i_rq1_vld = 1'b1; i_rq1_cls = cls; i_rq1_dtx = x; i_rq1_dty = y; i_rq1_tag = tag;
        end
    endtask

    task automatic chk_zero(input string name);
        #1;
        chk({name, "_rdy"}, 32'({o_rq0_rdy, o_rq1_rdy}), 32'd0);
        chk({name, "_shf"}, 32'({o_ps_shf_en, o_ps_shf_cls, o_xb_dtx, o_xb_dty}), 32'd0);
        chk({name, "_rsp"}, 32'({o_rsp_vld, o_rsp_id, o_rsp_tag, o_rsp_sv, o_rsp_sz}), 32'd0);
        chk({name, "_rsp_dt"}, 32'(o_rsp_dt), 32'd0);
        chk({name, "_sticky_busy"}, 32'({o_sv_sticky, o_busy}), 32'd0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        i_reset = 1'b1; i_cu_hold = 1'b0; i_clr_sticky = '0;
        i_rq0_cls = '0; i_rq0_dtx = '0; i_rq0_dty = '0; i_rq0_tag = '0;
        i_rq1_cls = '0; i_rq1_dtx = '0; i_rq1_dty = '0; i_rq1_tag = '0;
        idle();
        @(negedge clk);
        @(negedge clk);
        i_reset = 1'b0;
        model_clear();
        chk_zero("reset");

        // Single shift, fixed latency.
        req(0, 2'b00, 16'h0003, 16'h0002, 4'd5);
        tick();
        idle();
        drain(2);
        #1;
        chk("t1_vld", 32'(o_rsp_vld), 32'd1);
        chk("t1_dt", 32'(o_rsp_dt), 32'h000C);
        chk("t1_tag", 32'({o_rsp_id, o_rsp_tag}), 32'h05);
        drain(2);

        // Contention from reset: grants alternate starting with requester 0.
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req(0, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom_range(0, 15)), 4'(i));
            req(1, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom_range(0, 15)),
                4'(i + 8));
            #1;
            chk("t2_alt", 32'(o_rq1_rdy), 32'(i % 2));
            tick();
        end
        idle();
        drain(4);

        // Overflow sets sticky; a clear coinciding with a new set loses.
        req(1, 2'b00, 16'h4000, 16'h0001, 4'd3);
        tick();
        idle();
        drain(2);
        #1;
        chk("t3_dt", 32'({o_rsp_dt, o_rsp_sv}), 32'({16'h8000, 1'b1}));
        chk("t3_sticky", 32'(o_sv_sticky), 32'b10);
        drain(2);
        req(1, 2'b00, 16'h7000, 16'h0001, 4'd4);
        tick();
        idle();
        tick();
        i_clr_sticky = 2'b10;
        tick();
        i_clr_sticky = 2'b00;
        #1;
        chk("t3_set_wins", 32'(o_sv_sticky[1]), 32'd1);
        drain(2);
        i_clr_sticky = 2'b10;
        tick();
        i_clr_sticky = 2'b00;
        #1;
        chk("t3_cleared", 32'(o_sv_sticky[1]), 32'd0);
        tick();

        // Rotate and lead-zero count.
        req(0, 2'b01, 16'h8001, 16'h0001, 4'd6);
        tick();
        req(0, 2'b10, 16'h0000, 16'h0000, 4'd7);
        tick();
        idle();
        tick();
        #1;
        chk("t4_rot", 32'({o_rsp_dt, o_rsp_sv}), 32'({16'h0003, 1'b0}));
        tick();
        #1;
        chk("t4_lzc", 32'({o_rsp_dt, o_rsp_sv, o_rsp_sz}), 32'({16'h0010, 1'b1, 1'b0}));
        drain(2);

        // Hold blocks acceptance while earlier work drains.
        req(0, 2'b00, 16'h0101, 16'h0004, 4'd9);
        tick();
        i_cu_hold = 1'b1;
        req(0, 2'b11, 16'hF0F0, 16'h0000, 4'd10);
        req(1, 2'b11, 16'hFFFF, 16'h0000, 4'd11);
        drain(4);
        #1;
        chk("t5_busy", 32'(o_busy), 32'd0);
        i_cu_hold = 1'b0;
        #1;
        chk("t5_grant", 32'({o_rq0_rdy, o_rq1_rdy}), 32'b01);
        tick();
        idle();
        drain(4);

        // Reset mid-flight drops the op; a fresh request still completes.
        req(0, 2'b00, 16'h0001, 16'h0001, 4'd12);
        tick();
        idle();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        chk_zero("t6");
        drain(4);
        req(1, 2'b00, 16'h0011, 16'h0001, 4'd13);
        tick();
        idle();
        drain(2);
        #1;
        chk("t6_fresh", 32'({o_rsp_vld, o_rsp_id, o_rsp_tag, o_rsp_dt}),
            32'({1'b1, 1'b1, 4'd13, 16'h0022}));
        drain(2);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shf_arb.md
# shf_arb

Two-port arbiter and issue sequencer that shares the single `shifter` datapath in the control unit between two requesters (the instruction-decode path and the multi-step address/bit-field engine). It accepts one request per cycle, chosen round-robin, and drives the shifter's enable, class and operand inputs. It tracks each operation through the shifter's one-cycle input register and returns the result, flags, requester id and tag on a registered response port. It also keeps a per-requester sticky overflow flag.

## Interface
- `DATASIZE`, 16, operand/result width (must match shifter)
- `TAGW`, 4, requester tag width
- `clk` in 1: clock, rising edge
- `reset` in 1: synchronous, active-high reset
- `rq0_vld` / `rq1_vld` in 1: request valid
- `rq0_rdy` / `rq1_rdy` out 1: request accepted this cycle (may depend combinationally on both `rqN_vld` and `cu_hold`)
- `rq0_cls` / `rq1_cls` in 2: shifter class (00 shift, 01 rotate, 10 lead-zero count, 11 lead-one count)
- `rq0_dtx` / `rq1_dtx` in DATASIZE: operand X
- `rq0_dty` / `rq1_dty` in DATASIZE: operand Y (ignored by shifter for cls 1x)
- `rq0_tag` / `rq1_tag` in TAGW: opaque tag returned with the result
- `cu_hold` in 1: blocks new acceptance; in-flight ops still complete
- `ps_shf_en` out 1, `ps_shf_cls` out 2, `xb_dtx` / `xb_dty` out DATASIZE: to shifter
- `shf_xb_dt` in DATASIZE, `shf_ps_sv` in 1, `shf_ps_sz` in 1: from shifter
- `rsp_vld` out 1, `rsp_id` out 1, `rsp_tag` out TAGW, `rsp_dt` out DATASIZE, `rsp_sv` out 1, `rsp_sz` out 1: response
- `sv_sticky` out 2: per-requester sticky overflow
- `clr_sticky` in 2: clear `sv_sticky[n]`
- `busy` out 1: any op in flight (stage A, B or response register)

## Operation
- **Arbitration**
  - Priority pointer `ptr`; reset value 0.
  - Only one valid requester: it is granted.
  - Both valid: `rq[ptr]` is granted.
  - `rqN_rdy` = grant & ~`cu_hold` & ~`reset`. At most one `rdy` is high per cycle.
  - On accept, `ptr` <= other requester. With no accept, `ptr` holds.
- **No backpressure on responses**; requesters must consume `rsp_vld` in the cycle it is high. The pipeline never stalls.
- **Stage A (issue register)**
  - On accept: capture cls/dtx/dty/id/tag and set `a_vld` = 1; otherwise `a_vld` = 0.
  - `ps_shf_en` = `a_vld`.
  - `ps_shf_cls`, `xb_dtx`, `xb_dty` come from stage A registers and hold their last values when `a_vld` = 0.
- **Stage B** (op resident in shifter input register): `b_vld` <= `a_vld`; id and tag follow.
- **Response register**
  - When `b_vld`: capture `shf_xb_dt`, `shf_ps_sv`, `shf_ps_sz`, id and tag, and set `rsp_vld` = 1.
  - Otherwise `rsp_vld` = 0; data fields hold.
- **Sticky overflow**
  - `sv_sticky[id]` is set at the edge that raises `rsp_vld` with `shf_ps_sv` = 1.
  - `clr_sticky[n]` clears bit n.
  - Set and clear in the same cycle: set wins.
- **Reset values**
  - All outputs 0, `ptr` = 0, all valids 0.
  - Reset mid-operation drops every in-flight op; no response is ever produced for them.

## Timing
- Accept in cycle 0 (`rdy` & `vld` high) → `ps_shf_en` high in cycle 1 → shifter latches at end of cycle 1 → result valid in cycle 2 → `rsp_vld` high in cycle 3. Fixed latency 3 cycles.
- Throughput 1 op/cycle. Responses return in acceptance order, back-to-back.
- `cu_hold` takes effect in the same cycle: `rdy` is low and `ptr` is frozen. In-flight ops drain within 3 cycles.
- `busy` = `a_vld` | `b_vld` | `rsp_vld`.
- `rsp_*` and `sv_sticky` are registered. Only `rqN_rdy` is combinational.

## Test plan
1. Single shift: rq0 cls=00, dtx=0x0003, dty=0x0002, tag=5.
   - `ps_shf_en` high cycle 1.
   - `rsp_vld` cycle 3 with dt=0x000C, sv=0, sz=0, id=0, tag=5.
2. Contention: both requesters valid continuously from reset.
   - Grants alternate 0,1,0,1.
   - `rsp_vld` stays high from cycle 3 with ids 0,1,0,1 and the matching tags.
3. Overflow/sticky: rq1 cls=00, dtx=0x4000, dty=0x0001.
   - Response dt=0x8000, sv=1; `sv_sticky[1]` rises with `rsp_vld`.
   - `clr_sticky[1]` pulsed in the same cycle as another sv=1 response → `sv_sticky[1]` stays 1.
   - A later lone clear → 0.
4. Other classes:
   - cls=01, dtx=0x8001, dty=0x0001 → dt=0x0003, sv=0.
   - cls=10, dtx=0x0000 → dt=0x0010, sv=1, sz=0.
5. Hold: `cu_hold` high for 4 cycles with both requesters valid.
   - Both `rdy` low and no new `ps_shf_en`.
   - Earlier ops still respond; `busy` falls after drain.
   - After release, the grant goes to the requester `ptr` held.
6. Reset mid-flight: accept in cycle 0, `reset` high in cycle 1.
   - No `rsp_vld` afterwards; all outputs 0, `ptr` = 0.
   - A fresh request after reset completes normally.
